div_clk_monitor: RTL and testbench



---
 rtl/eyetracker_pkg.sv | 17 +
 rtl/edge_sync.sv | 47 ++++
 rtl/div_clk_monitor.sv | 165 ++++++++++++++++
 tb/tb_div_clk_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eyetracker_pkg.sv
// rtl/eyetracker_pkg.sv - shared types and defaults for the divided-clock monitor
//
// Purpose: state encoding and default counter width shared by div_clk_monitor.
// Ports:   none (package).

package eyetracker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } dcm_state_t;

  localparam int DCM_CNT_W = 8;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - synchroniser chain with registered rise/fall strobes
//
// Purpose: brings an asynchronous level into the clk domain and detects edges.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   din     in   asynchronous level to synchronise
//   rise    out  combinational rise (valid the cycle before rise_q)
//   fall    out  combinational fall (valid the cycle before fall_q)
//   rise_q  out  registered one-cycle rise strobe
//   fall_q  out  registered one-cycle fall strobe

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic rise_q,
  output logic fall_q
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   sync_last;

  assign sync_last = sync[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev;
  assign fall      = ~sync_last & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], din};
      prev   <= sync_last;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures period/high time of a divided clock in the CLK domain
//
// Purpose: edge strobes, period and high-time reporting, lock and timeout for a
//          slow divided clock sampled by the fast system clock.
// Ports:
//   CLK          in   system clock (rising edge)
//   RST_N        in   asynchronous active-low reset
//   iDIV_CLK     in   divided clock to measure, asynchronous to CLK
//   oRISE        out  one-cycle strobe per synchronised rising edge
//   oFALL        out  one-cycle strobe per synchronised falling edge
//   oMEAS_VALID  out  one-cycle strobe; oPERIOD/oHIGH updated this cycle
//   oPERIOD      out  CLK cycles between the last two rising edges
//   oHIGH        out  CLK cycles from previous rise to the following fall
//   oLOCKED      out  high while the period is stable
//   oTIMEOUT     out  high while no rise has arrived for 2^CNT_W-1 cycles

module div_clk_monitor
  import eyetracker_pkg::*;
#(
  parameter int CNT_W       = DCM_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             iDIV_CLK,
  output logic             oRISE,
  output logic             oFALL,
  output logic             oMEAS_VALID,
  output logic [CNT_W-1:0] oPERIOD,
  output logic [CNT_W-1:0] oHIGH,
  output logic             oLOCKED,
  output logic             oTIMEOUT
);

  localparam int               MC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] PCNT_MAX = '1;
  localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]  LOCK_V   = MC_W'(LOCK_COUNT);

  logic rise;
  logic fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .din    (iDIV_CLK),
    .rise   (rise),
    .fall   (fall),
    .rise_q (oRISE),
    .fall_q (oFALL)
  );

  dcm_state_t       state, state_n;
  logic [CNT_W-1:0] pcnt, hcnt, last_period, last_n;
  logic [MC_W-1:0]  match_cnt, match_n, match_inc;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             report;
  logic             timeout_n;

  // The combinational rise lines up with the edge that registers oRISE, so
  // pcnt still holds the full rise-to-rise count when it is reported.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt <= '0;
      hcnt <= '0;
    end else begin
      if (rise) begin
        pcnt <= CNT_W'(1);
      end else if (pcnt != PCNT_MAX) begin
        pcnt <= pcnt + 1'b1;
      end
      // Clearing on rise makes a missing fall report a high time of 0.
      if (rise) begin
        hcnt <= '0;
      end else if (fall) begin
        hcnt <= pcnt;
      end
    end
  end

  assign diff      = (pcnt >= last_period) ? ({1'b0, pcnt} - {1'b0, last_period})
                                           : ({1'b0, last_period} - {1'b0, pcnt});
  assign in_tol    = (diff <= TOL_V);
  assign match_inc = match_cnt + MC_W'(1);

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    last_n    = last_period;
    report    = 1'b0;
    timeout_n = oTIMEOUT;
    if (rise) begin
      timeout_n = 1'b0;
      unique case (state)
        IDLE: begin
          state_n = FIRST;
        end
        FIRST: begin
          report  = 1'b1;
          state_n = TRACK;
          match_n = '0;
          last_n  = pcnt;
        end
        TRACK: begin
          report = 1'b1;
          last_n = pcnt;
          if (in_tol) begin
            match_n = match_inc;
            if (match_inc == LOCK_V) begin
              state_n = LOCKED;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          report = 1'b1;
          last_n = pcnt;
          if (!in_tol) begin
            state_n = TRACK;
            match_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else if (pcnt >= PCNT_MAX - 1'b1) begin
      // pcnt reaches saturation on this edge (or is already there).
      state_n   = IDLE;
      match_n   = '0;
      timeout_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      match_cnt   <= '0;
      last_period <= '0;
      oMEAS_VALID <= 1'b0;
      oPERIOD     <= '0;
      oHIGH       <= '0;
      oTIMEOUT    <= 1'b0;
    end else begin
      state       <= state_n;
      match_cnt   <= match_n;
      last_period <= last_n;
      oMEAS_VALID <= report;
      oTIMEOUT    <= timeout_n;
      if (report) begin
        oPERIOD <= pcnt;
        oHIGH   <= hcnt;
      end
    end
  end

  assign oLOCKED = (state == LOCKED);

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor

module tb_div_clk_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_clk = 1'b0;
  logic       rise, fall, meas_valid, locked, timeout;
  logic [7:0] period, high;

  int total = 0;
  int passed = 0;

  int rise_cnt;
  int lock_rise;
  int first_rep_rise;
  int since_rise;
  int rep_per[$];
  int rep_high[$];
  int rep_lock[$];
  bit async_done;

  always #50 clk = ~clk;

  div_clk_monitor #(
    .CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(1)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .iDIV_CLK(div_clk),
    .oRISE(rise), .oFALL(fall), .oMEAS_VALID(meas_valid),
    .oPERIOD(period), .oHIGH(high), .oLOCKED(locked), .oTIMEOUT(timeout)
  );

  task automatic clear_log();
    rise_cnt = 0;
    lock_rise = 0;
    first_rep_rise = 0;
    since_rise = 0;
    rep_per.delete();
    rep_high.delete();
    rep_lock.delete();
  endtask

  // Drive one level for one CLK cycle and log what the outputs did.
  task automatic step(input logic lvl);
    div_clk = lvl;
    @(posedge clk);
    #1;
    if (rise) begin
      rise_cnt++;
      since_rise = 0;
    end else begin
      since_rise++;
    end
    if (meas_valid) begin
      rep_per.push_back(int'(period));
      rep_high.push_back(int'(high));
      rep_lock.push_back(int'(locked));
      if (first_rep_rise == 0) first_rep_rise = rise_cnt;
    end
    if (locked && lock_rise == 0) lock_rise = rise_cnt;
  endtask

  task automatic seg(input int p, input int h);
    for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic do_reset();
    div_clk = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    do_reset();
    outs = {rise, fall, meas_valid, period, high, locked, timeout};
    total++;
    if (outs !== 21'd0) $display("FAIL reset_outputs: got %h expected 0", outs); else passed++;
    repeat (3) step(1'b0);
    outs = {rise, fall, meas_valid, period, high, locked, timeout};
    total++;
    if (outs !== 21'd0) $display("FAIL idle_quiet: got %h expected 0", outs); else passed++;
  endtask

  task automatic test_edge_latency();
    logic [3:0] rpat, fpat;
    logic       any_meas;
    do_reset();
    any_meas = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      rpat[k] = rise;
      any_meas |= meas_valid;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      fpat[k] = fall;
    end
    total++;
    if (rpat !== 4'b0100) $display("FAIL rise_latency: got %b expected 0100", rpat); else passed++;
    total++;
    if (any_meas !== 1'b0) $display("FAIL first_rise_no_meas: got %b expected 0", any_meas); else passed++;
    total++;
    if (fpat !== 4'b0100) $display("FAIL fall_latency: got %b expected 0100", fpat); else passed++;
  endtask

  task automatic test_div8();
    int bad;
    do_reset();
    repeat (10) seg(8, 3);
    bad = 0;
    foreach (rep_per[i]) if (rep_per[i] != 8 || rep_high[i] != 3) bad++;
    total++;
    if (rep_per.size() != 9) $display("FAIL div8_reports: got %0d expected 9", rep_per.size()); else passed++;
    total++;
    if (rep_per[0] !== 8) $display("FAIL div8_first_period: got %0d expected 8", rep_per[0]); else passed++;
    total++;
    if (rep_high[0] !== 3) $display("FAIL div8_first_high: got %0d expected 3", rep_high[0]); else passed++;
    total++;
    if (bad != 0) $display("FAIL div8_all_reports: got %0d bad expected 0", bad); else passed++;
    total++;
    if (lock_rise != 6) $display("FAIL div8_lock_rise: got %0d expected 6", lock_rise); else passed++;
    total++;
    if (rep_lock[3] !== 0 || rep_lock[4] !== 1)
      $display("FAIL div8_lock_with_meas: got %0d%0d expected 01", rep_lock[3], rep_lock[4]);
    else passed++;
  endtask

  task automatic test_tolerance();
    int exp_per[7]  = '{8, 9, 11, 11, 11, 11, 11};
    int exp_lock[7] = '{1, 1, 0, 0, 0, 0, 1};
    clear_log();
    seg(9, 3);
    repeat (6) seg(11, 3);
    total++;
    if (rep_per.size() != 7) $display("FAIL tol_reports: got %0d expected 7", rep_per.size()); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (rep_per[i] !== exp_per[i])
        $display("FAIL tol_period[%0d]: got %0d expected %0d", i, rep_per[i], exp_per[i]);
      else passed++;
      total++;
      if (rep_lock[i] !== exp_lock[i])
        $display("FAIL tol_locked[%0d]: got %0d expected %0d", i, rep_lock[i], exp_lock[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic lock_before, to_before, hit, got_rise;
    int   n;
    do_reset();
    repeat (7) seg(8, 3);
    total++;
    if (locked !== 1'b1) $display("FAIL to_pre_locked: got %b expected 1", locked); else passed++;
    lock_before = locked;
    hit = 1'b0;
    for (n = 0; n < 400; n++) begin
      lock_before = locked;
      step(1'b0);
      if (timeout) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) $display("FAIL to_assert: got 0 expected 1 within 400 cycles"); else passed++;
    total++;
    if (since_rise != 254) $display("FAIL to_cycle: got %0d expected 254", since_rise); else passed++;
    total++;
    if (locked !== 1'b0 || lock_before !== 1'b1)
      $display("FAIL to_unlock: got %b->%b expected 1->0", lock_before, locked);
    else passed++;
    got_rise = 1'b0;
    to_before = timeout;
    for (int k = 0; k < 10; k++) begin
      to_before = timeout;
      step(1'b1);
      if (rise) begin
        got_rise = 1'b1;
        break;
      end
    end
    total++;
    if (!got_rise) $display("FAIL to_rise_seen: got 0 expected 1 within 10 cycles"); else passed++;
    total++;
    if (to_before !== 1'b1 || timeout !== 1'b0 || meas_valid !== 1'b0)
      $display("FAIL to_clear: got to %b->%b meas %b expected 1->0 meas 0", to_before, timeout, meas_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [20:0] outs;
    do_reset();
    repeat (7) seg(8, 3);
    total++;
    if (locked !== 1'b1) $display("FAIL rm_pre_locked: got %b expected 1", locked); else passed++;
    #20;
    rst_n = 1'b0;
    #1;
    outs = {rise, fall, meas_valid, period, high, locked, timeout};
    total++;
    if (outs !== 21'd0) $display("FAIL rm_async_clear: got %h expected 0", outs); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    repeat (4) seg(8, 3);
    total++;
    if (first_rep_rise != 2) $display("FAIL rm_first_report_rise: got %0d expected 2", first_rep_rise); else passed++;
    total++;
    if (rep_per[0] !== 8) $display("FAIL rm_first_period: got %0d expected 8", rep_per[0]); else passed++;
  endtask

  task automatic test_async();
    int  nrep, bad, lost;
    logic lock_set;
    do_reset();
    nrep = 0; bad = 0; lost = 0; lock_set = 1'b0;
    async_done = 1'b0;
    fork
      begin
        #($urandom_range(0, 99));
        repeat (200) begin
          div_clk = 1'b1;
          #668;
          div_clk = 1'b0;
          #669;
        end
        async_done = 1'b1;
      end
      begin
        while (!async_done) begin
          @(posedge clk);
          #1;
          if (meas_valid) begin
            nrep++;
            if (period != 8'd13 && period != 8'd14) bad++;
          end
          if (locked) lock_set = 1'b1;
          else if (lock_set) lost++;
        end
      end
    join
    total++;
    if (nrep != 199) $display("FAIL async_reports: got %0d expected 199", nrep); else passed++;
    total++;
    if (bad != 0) $display("FAIL async_period_range: got %0d bad expected 0", bad); else passed++;
    total++;
    if (lock_set !== 1'b1 || lost != 0)
      $display("FAIL async_lock_hold: got set %b lost %0d expected set 1 lost 0", lock_set, lost);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_div8();
    test_tolerance();
    test_timeout();
    test_reset_mid();
    test_async();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
